// File: rtl/layer_readout_arbiter.sv
// -----------------------------------------------------------------------------
// layer_readout_arbiter
//
// Shares one SPI readout engine between NUM_LAYERS sensor layers. Each layer
// raises an active-low interrupt. The arbiter picks a pending layer round-robin
// and holds that layer for SETUP_CYCLES. It then requests a readout and waits
// for the engine to finish or for the abort timer to expire. Finally it
// releases the hold.
//
// Ports
//   sysclk            : single clock, rising edge
//   warm_resn         : active-low reset, asserted async, released sync
//   layer_enable      : per-layer service enable (sysclk domain)
//   layer_interruptn  : per-layer chip interrupt, active low, asynchronous
//   layer_hold        : per-layer hold, registered
//   hold_all          : host request forcing every hold high (1-cycle latency)
//   rd_req            : readout request to engine, registered
//   rd_layer          : index of granted layer
//   rd_ack / rd_done  : engine accept / finish pulses
//   rd_timeout_cycles : abort limit in cycles, 0 disables the abort timer
//   busy              : FSM not idle
//   timeout_pulse     : one-cycle pulse per aborted readout
//   timeout_count     : saturating count of aborts
// -----------------------------------------------------------------------------
module layer_readout_arbiter #(
  parameter int NUM_LAYERS   = 20,
  parameter int SETUP_CYCLES = 4,
  parameter int TMO_W        = 16
) (
  input  logic                  sysclk,
  input  logic                  warm_resn,
  input  logic [NUM_LAYERS-1:0] layer_enable,
  input  logic [NUM_LAYERS-1:0] layer_interruptn,
  output logic [NUM_LAYERS-1:0] layer_hold,
  input  logic                  hold_all,
  output logic                  rd_req,
  output logic [4:0]            rd_layer,
  input  logic                  rd_ack,
  input  logic                  rd_done,
  input  logic [TMO_W-1:0]      rd_timeout_cycles,
  output logic                  busy,
  output logic                  timeout_pulse,
  output logic [7:0]            timeout_count
);

  localparam int              SW         = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
  localparam logic [SW-1:0]   SETUP_LAST = SW'(SETUP_CYCLES - 1);
  localparam logic [4:0]      LAST_LAYER = 5'(NUM_LAYERS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_REQ,
    ST_WAIT,
    ST_RELEASE
  } state_t;

  state_t                  state_reg;
  logic [1:0]              rst_sync_reg;
  logic                    rst_n;
  logic [NUM_LAYERS-1:0]   intn_meta_reg;
  logic [NUM_LAYERS-1:0]   intn_sync_reg;
  logic [NUM_LAYERS-1:0]   pending_reg;
  logic [NUM_LAYERS-1:0]   layer_hold_reg;
  logic [NUM_LAYERS-1:0]   hold_fsm_next;
  logic [4:0]              rd_layer_reg;
  logic [4:0]              last_grant_reg;
  logic [4:0]              winner;
  logic [SW-1:0]           setup_cnt_reg;
  logic [TMO_W-1:0]        tmo_cnt_reg;
  logic [TMO_W-1:0]        tmo_cnt_inc;
  logic [7:0]              timeout_count_reg;
  logic                    rd_req_reg;
  logic                    timeout_pulse_reg;
  logic                    any_pending;
  logic                    grant_start;
  logic                    go_release;
  logic                    tmo_hit;

  // Reset: warm_resn clears everything at once; the internal reset is only
  // released two sysclk edges after warm_resn rises.
  always_ff @(posedge sysclk or negedge warm_resn) begin
    if (!warm_resn) begin
      rst_sync_reg <= 2'b00;
    end else begin
      rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_reg[1];

  // Two-flop synchronizer for the interrupts. It is followed by one
  // registered pending stage, so a falling interrupt reaches the hold three
  // edges later.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      intn_meta_reg <= '1;
      intn_sync_reg <= '1;
      pending_reg   <= '0;
    end else begin
      intn_meta_reg <= layer_interruptn;
      intn_sync_reg <= intn_meta_reg;
      pending_reg   <= layer_enable & ~intn_sync_reg;
    end
  end

  assign any_pending = |pending_reg;

  // Layer index that is 'offset' positions after the previous grant,
  // wrapping at NUM_LAYERS.
  function automatic logic [4:0] rr_index(input logic [4:0] base, input int offset);
    int pos;
    pos = int'(base) + 1 + offset;
    if (pos >= NUM_LAYERS) begin
      pos = pos - NUM_LAYERS;
    end
    return 5'(pos);
  endfunction

  // Scan from the farthest candidate to the nearest one, so the layer right
  // after last_grant wins.
  always_comb begin
    winner = '0;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (pending_reg[rr_index(last_grant_reg, k)]) begin
        winner = rr_index(last_grant_reg, k);
      end
    end
  end

  assign tmo_cnt_inc = tmo_cnt_reg + TMO_W'(1);
  assign tmo_hit     = (rd_timeout_cycles != '0) && (tmo_cnt_inc == rd_timeout_cycles);
  assign grant_start = (state_reg == ST_IDLE) && any_pending;

  // Priority: a completed readout wins over an abort, and an abort wins
  // over a plain ack.
  always_comb begin
    go_release = 1'b0;
    case (state_reg)
      ST_GRANT: go_release = !layer_enable[rd_layer_reg];
      ST_REQ:   go_release = (rd_ack && rd_done) || tmo_hit;
      ST_WAIT:  go_release = rd_done || tmo_hit;
      default:  go_release = 1'b0;
    endcase
  end

  // Hold vector the FSM wants after this edge. This lets hold rise on the
  // same edge that enters GRANT and fall on the edge that enters RELEASE.
  always_comb begin
    hold_fsm_next = '0;
    if (grant_start) begin
      hold_fsm_next[winner] = 1'b1;
    end else if (!go_release &&
                 (state_reg == ST_GRANT || state_reg == ST_REQ || state_reg == ST_WAIT)) begin
      hold_fsm_next[rd_layer_reg] = 1'b1;
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      layer_hold_reg <= '0;
    end else begin
      layer_hold_reg <= hold_all ? '1 : hold_fsm_next;
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= ST_IDLE;
      rd_req_reg        <= 1'b0;
      rd_layer_reg      <= '0;
      last_grant_reg    <= LAST_LAYER;
      setup_cnt_reg     <= '0;
      tmo_cnt_reg       <= '0;
      timeout_pulse_reg <= 1'b0;
      timeout_count_reg <= '0;
    end else begin
      timeout_pulse_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (any_pending) begin
            state_reg     <= ST_GRANT;
            rd_layer_reg  <= winner;
            setup_cnt_reg <= '0;
          end
        end
        ST_GRANT: begin
          if (!layer_enable[rd_layer_reg]) begin
            state_reg <= ST_RELEASE;
          end else if (setup_cnt_reg == SETUP_LAST) begin
            state_reg   <= ST_REQ;
            rd_req_reg  <= 1'b1;
            tmo_cnt_reg <= '0;
          end else begin
            setup_cnt_reg <= setup_cnt_reg + SW'(1);
          end
        end
        ST_REQ: begin
          if (rd_ack && rd_done) begin
            rd_req_reg <= 1'b0;
            state_reg  <= ST_RELEASE;
          end else if (tmo_hit) begin
            rd_req_reg        <= 1'b0;
            timeout_pulse_reg <= 1'b1;
            if (timeout_count_reg != 8'hFF) begin
              timeout_count_reg <= timeout_count_reg + 8'd1;
            end
            state_reg <= ST_RELEASE;
          end else if (rd_ack) begin
            rd_req_reg  <= 1'b0;
            tmo_cnt_reg <= tmo_cnt_inc;
            state_reg   <= ST_WAIT;
          end else begin
            tmo_cnt_reg <= tmo_cnt_inc;
          end
        end
        ST_WAIT: begin
          if (rd_done) begin
            state_reg <= ST_RELEASE;
          end else if (tmo_hit) begin
            timeout_pulse_reg <= 1'b1;
            if (timeout_count_reg != 8'hFF) begin
              timeout_count_reg <= timeout_count_reg + 8'd1;
            end
            state_reg <= ST_RELEASE;
          end else begin
            tmo_cnt_reg <= tmo_cnt_inc;
          end
        end
        ST_RELEASE: begin
          last_grant_reg <= rd_layer_reg;
          state_reg      <= ST_IDLE;
        end
        default: begin
          state_reg  <= ST_IDLE;
          rd_req_reg <= 1'b0;
        end
      endcase
    end
  end

  assign layer_hold    = layer_hold_reg;
  assign rd_req        = rd_req_reg;
  assign rd_layer      = rd_layer_reg;
  assign busy          = (state_reg != ST_IDLE);
  assign timeout_pulse = timeout_pulse_reg;
  assign timeout_count = timeout_count_reg;

endmodule

// File: doc/layer_readout_arbiter.md
LAYER_READOUT_ARBITER -- requirements
Module: layer_readout_arbiter

Interface
REQ-001 Parameter NUM_LAYERS, default 20: number of layer (row) ports served.
REQ-002 Parameter SETUP_CYCLES, default 4: cycles hold is asserted before read request.
REQ-003 Parameter TMO_W, default 16: width of timeout configuration/counter.
REQ-004 sysclk  in  1  single clock; all logic on rising edge.
REQ-005 warm_resn  in  1  asynchronous active-low reset; assert async, release sync to sysclk.
REQ-006 layer_enable  in  NUM_LAYERS  per-layer service enable (config register, sysclk domain).
REQ-007 layer_interruptn  in  NUM_LAYERS  chip interrupt, active low, asynchronous.
REQ-008 layer_hold  out  NUM_LAYERS  per-layer hold, active high, registered.
REQ-009 hold_all  in  1  host request forcing all holds high.
REQ-010 rd_req  out  1  readout request to shared SPI readout engine, registered.
REQ-011 rd_layer  out  5  index of granted layer, stable while rd_req or hold active.
REQ-012 rd_ack  in  1  engine accepted request (one-cycle pulse).
REQ-013 rd_done  in  1  engine finished layer readout (one-cycle pulse).
REQ-014 rd_timeout_cycles  in  TMO_W  abort limit; 0 disables timeout.
REQ-015 busy  out  1  high whenever FSM not in IDLE.
REQ-016 timeout_pulse  out  1  one-cycle pulse per aborted readout.
REQ-017 timeout_count  out  8  saturating count of aborts.

Function
REQ-018 layer_interruptn SHALL pass a 2-flop synchronizer; pending[i] = layer_enable[i] AND NOT sync_intn[i].
REQ-019 FSM states SHALL be IDLE, GRANT, REQ, WAIT, RELEASE.
REQ-020 IDLE: if any pending, select winner round-robin starting at last_grant+1 mod NUM_LAYERS, wrap NUM_LAYERS-1 -> 0; go GRANT; else stay.
REQ-021 On entry to GRANT, rd_layer SHALL load winner and layer_hold[winner] SHALL go high same edge.
REQ-022 GRANT SHALL last exactly SETUP_CYCLES cycles, then REQ with rd_req high.
REQ-023 If layer_enable[rd_layer] drops during GRANT, go RELEASE without issuing rd_req.
REQ-024 REQ: rd_req held high until rd_ack sampled high; rd_req low the following cycle; go WAIT.
REQ-025 rd_ack and rd_done high in same cycle in REQ: treat as complete, go RELEASE.
REQ-026 WAIT: on rd_done go RELEASE; rd_done/rd_ack outside REQ/WAIT SHALL be ignored.
REQ-027 Timeout counter SHALL clear on entry to REQ, increment each cycle in REQ/WAIT; when equal to nonzero rd_timeout_cycles: rd_req low, timeout_pulse 1 cycle, timeout_count+1 (saturate 255), go RELEASE.
REQ-028 RELEASE (1 cycle): layer_hold[rd_layer] low, last_grant <= rd_layer, return IDLE; a new grant cannot start before the next cycle.
REQ-029 Latency: interruptn falling at edge N (setup met) -> hold high after edge N+3 -> rd_req high after edge N+3+SETUP_CYCLES.
REQ-030 hold_all high SHALL force all layer_hold high combinationally-free (registered, 1-cycle latency) without altering FSM; releasing restores FSM-driven holds.
REQ-031 Changing layer_enable of non-granted layers SHALL only affect next arbitration.
REQ-032 At most one layer_hold bit SHALL be high at any time when hold_all low.

Reset
REQ-033 On warm_resn low: FSM IDLE, layer_hold 0, rd_req 0, rd_layer 0, busy 0, timeout_pulse 0, timeout_count 0, last_grant NUM_LAYERS-1 (first arbitration favours layer 0), synchronizers 1 (no interrupt).
REQ-034 Reset mid-operation SHALL drop rd_req and holds immediately (asynchronous), with no timeout_pulse.

Verification
REQ-035 Layer 5 only enabled, interruptn5 low -> hold[5] high 3 cycles later, rd_req 4 cycles after, rd_ack+rd_done -> hold[5] low, busy low.
REQ-036 Layers 0,7,19 pending continuously, instant ack/done -> grant order 0,7,19,0,7 (wrap verified).
REQ-037 rd_timeout_cycles=10, engine never done -> abort 10 cycles after REQ entry, timeout_pulse once, timeout_count=1; 300 aborts -> count 255.
REQ-038 rd_ack and rd_done same cycle -> RELEASE next, single readout, no timeout.
REQ-039 layer_enable[3] cleared during GRANT of layer 3 -> no rd_req, hold[3] low after RELEASE.
REQ-040 warm_resn low during WAIT -> all outputs reset values same cycle; after release, pending layer 0 granted first.
